// File: rtl/conv_mdc_package.sv
// Shared types and widths for the conv_mdc adapter slice: frame sequencer states,
// counter widths and the upstream job descriptor.
`timescale 1ns/1ps
package conv_mdc_package;

  localparam int unsigned CONV_MDC_FRM_CNT_W  = 16;
  localparam int unsigned CONV_MDC_BEAT_CNT_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } frame_ctrl_state_e;

  typedef struct packed {
    logic                          start;
    logic [31:0]                   width;
    logic [31:0]                   height;
    logic [CONV_MDC_FRM_CNT_W-1:0] n_frames;
  } ctrl_frame_t;

  // Full-precision pixel count of one frame; callers keep the low bits they need.
  function automatic logic [63:0] beat_total(input logic [31:0] w, input logic [31:0] h);
    return 64'(w) * 64'(h);
  endfunction

endpackage

// File: rtl/conv_mdc_beat_counter.sv
// Beat counter with synchronous clear and a level flag that is high once the
// count has reached the supplied limit.
`timescale 1ns/1ps
module conv_mdc_beat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic [CNT_W-1:0] count_o,
  output logic             reached_o
);

  logic [CNT_W-1:0] count_r;

  // Count register: clear has priority over increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_r <= '0;
    end else if (clear_i) begin
      count_r <= '0;
    end else if (en_i) begin
      count_r <= count_r + CNT_W'(1'b1);
    end
  end

  assign count_o   = count_r;
  assign reached_o = (count_r >= limit_i);

endmodule

// File: rtl/conv_mdc_frame_ctrl.sv
// Frame sequencer for the conv_mdc kernel adapter: latches a job, issues one kernel
// start per frame and gates the input stream so frames never overlap.
`timescale 1ns/1ps
module conv_mdc_frame_ctrl
  import conv_mdc_package::*;
#(
  parameter int unsigned CNT_W = CONV_MDC_BEAT_CNT_W,
  parameter int unsigned FRM_W = CONV_MDC_FRM_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             test_mode_i,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic [31:0]      width_i,
  input  logic [31:0]      height_i,
  input  logic [FRM_W-1:0] n_frames_i,
  input  logic             src_fire_i,
  input  logic             dst_fire_i,
  output logic             src_en_o,
  output logic             kernel_start_o,
  output logic [31:0]      width_o,
  output logic [31:0]      height_o,
  output logic [FRM_W-1:0] frame_idx_o,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic             done_o,
  output logic             err_o
);

  frame_ctrl_state_e state_r, state_n;
  logic [31:0]       width_r, width_n;
  logic [31:0]       height_r, height_n;
  logic [FRM_W-1:0]  n_frames_r, n_frames_n;
  logic [FRM_W-1:0]  frame_idx_r, frame_idx_n;
  logic [CNT_W-1:0]  total_r, total_n;
  logic              err_r, err_n;
  logic              frame_done_r, frame_done_n;

  logic [63:0]       prod_s;
  logic [CNT_W-1:0]  total_load_s;
  logic [CNT_W-1:0]  in_cnt_s, out_cnt_s;
  logic [CNT_W:0]    in_after_s, out_after_s;
  logic              in_reached_s, out_reached_s;
  logic              src_en_s, in_inc_s, out_inc_s, last_beat_s;
  logic              err_evt_s, cnt_clr_s;
  logic              unused_s;

  assign unused_s = test_mode_i ^ out_reached_s;

  assign prod_s       = beat_total(width_r, height_r);
  assign total_load_s = prod_s[CNT_W-1:0];

  assign src_en_s  = (state_r == RUN) && !in_reached_s;
  assign in_inc_s  = (state_r == RUN) && src_fire_i && src_en_s;
  assign out_inc_s = (state_r == RUN) && dst_fire_i;
  assign cnt_clr_s = clear_i || (state_r == START) || ((state_r == IDLE) && start_i);

  // Overflow check counts a same-cycle input beat before comparing.
  assign in_after_s  = {1'b0, in_cnt_s} + {{CNT_W{1'b0}}, in_inc_s};
  assign out_after_s = {1'b0, out_cnt_s} + {{CNT_W{1'b0}}, 1'b1};
  assign last_beat_s = out_inc_s && (out_after_s == {1'b0, total_r});
  assign err_evt_s   = (src_fire_i && !src_en_s)
                     || (dst_fire_i && (state_r != RUN))
                     || (out_inc_s && (out_after_s > in_after_s));

  conv_mdc_beat_counter #(.CNT_W(CNT_W)) u_in_cnt (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (cnt_clr_s),
    .en_i      (in_inc_s),
    .limit_i   (total_r),
    .count_o   (in_cnt_s),
    .reached_o (in_reached_s)
  );

  conv_mdc_beat_counter #(.CNT_W(CNT_W)) u_out_cnt (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (cnt_clr_s),
    .en_i      (out_inc_s),
    .limit_i   (total_r),
    .count_o   (out_cnt_s),
    .reached_o (out_reached_s)
  );

  // Next-state and next-register values for the job sequencer.
  always_comb begin
    state_n      = state_r;
    width_n      = width_r;
    height_n     = height_r;
    n_frames_n   = n_frames_r;
    frame_idx_n  = frame_idx_r;
    total_n      = total_r;
    frame_done_n = 1'b0;
    err_n        = err_r | err_evt_s;
    case (state_r)
      IDLE: begin
        if (start_i) begin
          state_n     = LOAD;
          width_n     = width_i;
          height_n    = height_i;
          n_frames_n  = n_frames_i;
          frame_idx_n = '0;
          total_n     = '0;
          err_n       = 1'b0;
        end else begin
          state_n = IDLE;
        end
      end
      LOAD: begin
        total_n = total_load_s;
        // A product that truncates to zero would never finish a frame.
        if ((width_r == 32'd0) || (height_r == 32'd0) || (n_frames_r == '0)
            || (total_load_s == '0)) begin
          err_n   = 1'b1;
          state_n = DONE;
        end else begin
          state_n = START;
        end
      end
      START: begin
        state_n = RUN;
      end
      RUN: begin
        if (last_beat_s) begin
          frame_done_n = 1'b1;
          if ((frame_idx_r + FRM_W'(1'b1)) == n_frames_r) begin
            state_n = DONE;
          end else begin
            frame_idx_n = frame_idx_r + FRM_W'(1'b1);
            state_n     = START;
          end
        end else begin
          state_n = RUN;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Sequencer registers; soft clear zeroes everything like reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r      <= IDLE;
      width_r      <= 32'd0;
      height_r     <= 32'd0;
      n_frames_r   <= '0;
      frame_idx_r  <= '0;
      total_r      <= '0;
      err_r        <= 1'b0;
      frame_done_r <= 1'b0;
    end else if (clear_i) begin
      state_r      <= IDLE;
      width_r      <= 32'd0;
      height_r     <= 32'd0;
      n_frames_r   <= '0;
      frame_idx_r  <= '0;
      total_r      <= '0;
      err_r        <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_n;
      width_r      <= width_n;
      height_r     <= height_n;
      n_frames_r   <= n_frames_n;
      frame_idx_r  <= frame_idx_n;
      total_r      <= total_n;
      err_r        <= err_n;
      frame_done_r <= frame_done_n;
    end
  end

  assign src_en_o       = src_en_s;
  assign kernel_start_o = (state_r == START);
  assign busy_o         = (state_r != IDLE);
  assign done_o         = (state_r == DONE);
  assign frame_done_o   = frame_done_r;
  assign err_o          = err_r;
  assign width_o        = width_r;
  assign height_o       = height_r;
  assign frame_idx_o    = frame_idx_r;

endmodule

// File: tb/tb_conv_mdc_frame_ctrl.sv
// Directed + randomized bench for conv_mdc_frame_ctrl; jobs are judged against
// per-job totals derived from width, height and frame count.
`timescale 1ns/1ps
module tb_conv_mdc_frame_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        test_mode_i = 1'b0;
  logic        clear_i = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] width_i = 32'd0;
  logic [31:0] height_i = 32'd0;
  logic [15:0] n_frames_i = 16'd0;
  logic        src_fire_i = 1'b0;
  logic        dst_fire_i = 1'b0;
  logic        src_en_o, kernel_start_o, busy_o, frame_done_o, done_o, err_o;
  logic [31:0] width_o, height_o;
  logic [15:0] frame_idx_o;

  int errors = 0;
  int checks = 0;

  conv_mdc_frame_ctrl dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .test_mode_i    (test_mode_i),
    .clear_i        (clear_i),
    .start_i        (start_i),
    .width_i        (width_i),
    .height_i       (height_i),
    .n_frames_i     (n_frames_i),
    .src_fire_i     (src_fire_i),
    .dst_fire_i     (dst_fire_i),
    .src_en_o       (src_en_o),
    .kernel_start_o (kernel_start_o),
    .width_o        (width_o),
    .height_o       (height_o),
    .frame_idx_o    (frame_idx_o),
    .busy_o         (busy_o),
    .frame_done_o   (frame_done_o),
    .done_o         (done_o),
    .err_o          (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Runs one job with random input traffic and an output loopback delayed by dmin..dmax cycles.
  task automatic run_job(input int w, input int h, input int n, input bit inj_start,
                         input int dmin, input int dmax);
    int  starts = 0, fdones = 0, dones = 0, acc = 0, frame_in = 0;
    int  viol = 0, idx_bad = 0, exp_idx = 0, total;
    bit  armed = 1'b0, exp_en, got_done = 1'b0, injected = 1'b0, src_d, dst_d, valid;
    int  q[$];
    valid = (w != 0) && (h != 0) && (n != 0);
    total = w * h;
    start_i = 1'b1; width_i = w; height_i = h; n_frames_i = n[15:0];
    tick();
    start_i = 1'b0;
    check("err_clr_on_start", err_o, 0);
    for (int cyc = 0; cyc < 3000 && !got_done; cyc++) begin
      if (kernel_start_o) begin
        starts++;
        if (frame_idx_o != exp_idx[15:0]) idx_bad++;
        exp_idx++;
        frame_in = 0;
        armed = 1'b1;
        exp_en = 1'b0;
      end else begin
        exp_en = armed && (frame_in < total);
      end
      if (src_en_o !== exp_en) viol++;
      if (frame_done_o) fdones++;
      if (done_o) begin
        dones++;
        got_done = 1'b1;
        armed = 1'b0;
      end
      start_i = 1'b0;
      if (inj_start && armed && !kernel_start_o && frame_in == 1 && !injected) begin
        start_i = 1'b1; width_i = 32'd7; height_i = 32'd7; n_frames_i = 16'd5;
        injected = 1'b1;
      end
      src_d = src_en_o && ($urandom_range(0, 3) != 0);
      if (src_d) begin
        frame_in++;
        acc++;
        q.push_back(cyc + int'($urandom_range(dmin, dmax)));
      end
      dst_d = (q.size() > 0) && (q[0] <= cyc);
      if (dst_d) void'(q.pop_front());
      src_fire_i = src_d;
      dst_fire_i = dst_d;
      tick();
    end
    start_i = 1'b0; src_fire_i = 1'b0; dst_fire_i = 1'b0;
    check("kernel_starts", starts, valid ? n : 0);
    check("frame_dones", fdones, valid ? n : 0);
    check("done_pulses", dones, 1);
    check("accepted_src", acc, valid ? n * w * h : 0);
    check("src_en_timing", viol, 0);
    check("frame_idx_seq", idx_bad, 0);
    check("err_at_end", err_o, valid ? 0 : 1);
    check("busy_after_done", busy_o, 0);
    check("width_held", width_o, w);
    check("height_held", height_o, h);
  endtask

  initial begin
    int done_seen;
    #12;
    check("reset_outputs", {busy_o, src_en_o, kernel_start_o, frame_done_o, done_o, err_o}, 0);
    check("reset_width", width_o, 0);
    check("reset_frame_idx", frame_idx_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();

    // single frame, fixed two-cycle loopback
    run_job(4, 3, 1, 1'b0, 2, 2);
    // three 2x2 frames
    run_job(2, 2, 3, 1'b0, 2, 4);
    // zero dimension and zero frame count
    run_job(0, 5, 1, 1'b0, 2, 2);
    run_job(2, 2, 0, 1'b0, 2, 2);

    // protocol errors in IDLE, sticky until the next accepted start
    src_fire_i = 1'b1; tick(); src_fire_i = 1'b0;
    check("err_src_while_disabled", err_o, 1);
    repeat (3) tick();
    check("err_sticky", err_o, 1);
    run_job(1, 2, 1, 1'b0, 2, 3);
    dst_fire_i = 1'b1; tick(); dst_fire_i = 1'b0;
    check("err_dst_outside_run", err_o, 1);

    // clear in the middle of a 4x4 frame after five inputs
    start_i = 1'b1; width_i = 32'd4; height_i = 32'd4; n_frames_i = 16'd1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 10 && !kernel_start_o; i++) tick();
    check("clr_kernel_start", kernel_start_o, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      src_fire_i = 1'b1; tick();
    end
    src_fire_i = 1'b0;
    check("clr_src_en_before", src_en_o, 1);
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    check("clr_outputs", {busy_o, src_en_o, kernel_start_o, frame_done_o, done_o, err_o}, 0);
    check("clr_width", width_o, 0);
    done_seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (done_o) done_seen++;
      tick();
    end
    check("clr_no_done", done_seen, 0);
    run_job(1, 1, 1, 1'b0, 2, 2);

    // start_i during RUN is ignored
    run_job(3, 2, 2, 1'b1, 2, 4);

    // asynchronous reset in the middle of a frame
    start_i = 1'b1; width_i = 32'd3; height_i = 32'd3; n_frames_i = 16'd2;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 10 && !kernel_start_o; i++) tick();
    tick();
    src_fire_i = 1'b1; tick(); tick(); src_fire_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    check("rst_async_outputs", {busy_o, src_en_o, kernel_start_o, frame_done_o, done_o, err_o}, 0);
    check("rst_async_dims", {width_o, height_o}, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    run_job(2, 3, 1, 1'b0, 2, 2);

    // randomized jobs
    for (int j = 0; j < 4; j++) begin
      run_job(int'($urandom_range(1, 5)), int'($urandom_range(1, 5)),
              int'($urandom_range(1, 3)), 1'b0, 2, 5);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_mdc_frame_ctrl.md
Name: conv_mdc_frame_ctrl

Overview:
Frame-level sequencer for the conv_mdc kernel adapter. Latches a job of N frames of width x height pixels and issues one kernel start per frame. Counts accepted input and output beats, and gates the input stream so that no beat of frame k+1 enters before frame k has drained. Sits between the HWPE controller (register file/FSM) and conv_mdc_kernel_adapter; it drives the adapter's ctrl start and kernel parameters.

Parameters:
CNT_W, 32, width of beat counters and of the per-frame beat total (width*height truncated to CNT_W)
FRM_W, 16, width of frame count and frame counter

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active low
test_mode_i  in  1  test mode; no functional effect
clear_i  in  1  synchronous soft clear, highest priority after reset
start_i  in  1  job start pulse; honoured only in IDLE
width_i  in  32  frame width in pixels, sampled on accepted start_i
height_i  in  32  frame height in pixels, sampled on accepted start_i
n_frames_i  in  FRM_W  frames per job, sampled on accepted start_i
src_fire_i  in  1  src_V valid&ready observed at the adapter
dst_fire_i  in  1  dst_V valid&ready observed at the adapter
src_en_o  out  1  input stream enable (ANDed into src valid/ready upstream)
kernel_start_o  out  1  one-cycle start to adapter ctrl_i.start
width_o  out  32  latched width to kernel
height_o  out  32  latched height to kernel
frame_idx_o  out  FRM_W  index of the current frame
busy_o  out  1  high in every state except IDLE
frame_done_o  out  1  one-cycle pulse per completed frame
done_o  out  1  one-cycle pulse at job end
err_o  out  1  sticky error; cleared by accepted start_i or clear_i

Behaviour:
- Clock clk_i; reset rst_ni is asynchronous and active low. In reset all state is zeroed, FSM=IDLE, and all outputs are 0.
- States: IDLE, LOAD, START, RUN, DONE.
- IDLE: on start_i, latch width, height and n_frames; clear err, frame_idx and counters; go to LOAD.
- LOAD (1 cycle): total <= width*height, taking the low CNT_W bits.
  - If width==0, height==0 or n_frames==0: set err_o and go to DONE without any kernel start.
  - Otherwise go to START.
- START (1 cycle): kernel_start_o=1; in_cnt and out_cnt cleared; go to RUN. Start-to-first-enable latency is 1 cycle.
- RUN:
  - src_en_o = (in_cnt < total), combinational from registered in_cnt.
  - in_cnt increments on src_fire_i && src_en_o.
  - out_cnt increments on dst_fire_i.
  - Simultaneous src and dst fires both count in the same cycle.
  - When out_cnt reaches total (the cycle of the last dst_fire):
    - register frame_done_o=1 for the next cycle;
    - if frame_idx+1==n_frames, go to DONE;
    - otherwise increment frame_idx and go to START.
  - Minimum gap between frames is one START cycle.
- DONE (1 cycle): done_o=1; go to IDLE.
- src_fire_i while src_en_o=0, or dst_fire_i outside RUN: ignored for counting and sets err_o (sticky).
- A dst_fire_i that would make out_cnt exceed in_cnt also sets err_o; the counter still increments.
- start_i outside IDLE is ignored (no error).
- clear_i: all state returns to IDLE next cycle, outputs zeroed, and no done_o pulse. If start_i and clear_i coincide, clear_i wins.
- Reset mid-frame: immediate return to IDLE with outputs 0.
- width_o and height_o hold the latched values until the next accepted start_i.

Decomposition:
- Add to conv_mdc_package:
  - typedef frame_ctrl_state_e (IDLE, LOAD, START, RUN, DONE);
  - constants CONV_MDC_FRM_CNT_W=16 and CONV_MDC_BEAT_CNT_W=32;
  - a struct ctrl_frame_t {start, width, height, n_frames} for the upstream interface.
- One natural sub-module: conv_mdc_beat_counter (clear, enable, limit, count, reached), instantiated twice for in_cnt and out_cnt.

Test Plan:
1. Single frame: width=4, height=3, n=1; drive the input and loop output back after a 2-cycle delay.
   - kernel_start_o pulses once; exactly 12 src fires are enabled.
   - src_en_o drops after the 12th input; frame_done_o and done_o each pulse once; busy_o drops.
2. Three frames, 2x2: start pulses 3 times; frame_idx_o steps 0,1,2; 3 frame_done_o pulses; src_en_o stays 0 between the 4th input and the next START.
3. Zero dimension: width=0, height=5: err_o=1, done_o pulses, kernel_start_o never asserts.
4. Protocol errors:
   - src_fire_i injected while src_en_o=0 raises err_o;
   - err_o stays high until the next accepted start_i.
5. Mid-frame interruption: clear_i asserted mid-RUN (in_cnt=5 of 16) returns to IDLE with no done_o. A subsequent start_i with 1x1 completes normally.
6. Simultaneous events:
   - start_i during RUN has no effect;
   - rst_ni asserted mid-frame zeroes all outputs asynchronously;
   - same-cycle src and dst fires increment both counters.
